xor_stream_descrambler: RTL and testbench
=========================================

Name: xor_stream_descrambler

Overview:
- Receive-side descrambler for 32-bit word streams.
- Strips an additive LFSR keystream that the matching transmit-side scrambler applied with a bitwise XOR.
- Sits between the link input buffer and the datapath consumer, using valid/ready handshakes on both sides.
- Holds a Galois LFSR state machine, a single output register stage with backpressure, and a word counter.

Parameters:
- WIDTH, 32, data and LFSR width in bits.
- POLY, 32'h04C11DB7, Galois feedback polynomial, applied when the LFSR MSB is 1.
- SEED_DEFAULT, 32'hFFFFFFFF, seed substituted when a zero seed is loaded.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- seed_load  input  1  synchronous seed load strobe, one cycle.
- seed  input  WIDTH  seed value, sampled when seed_load=1.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept the word this cycle.
- in_data  input  WIDTH  scrambled word.
- out_valid  output  1  out_data holds a descrambled word.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  descrambled word.
- word_count  output  16  words accepted since the last seed load; wraps.
- synced  output  1  1 when state is RUN.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT_SEED, lfsr=SEED_DEFAULT, out_valid=0, out_data=0, word_count=0.
  - in_ready=0 and synced=0, because both are derived from state.
- States:
  - WAIT_SEED: in_ready=0. seed_load → RUN.
  - RUN: streaming. seed_load stays in RUN but re-seeds. No other exit except reset.
- Seed load (seed_load=1, either state):
  - lfsr <= (seed==0) ? SEED_DEFAULT : seed.
  - out_valid <= 0 (pending word discarded), word_count <= 0.
  - in_ready=0 that cycle, so no word is accepted.
  - seed_load has priority over every other event.
- Handshake:
  - in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
  - Accept = in_valid && in_ready. On accept:
    - out_data <= in_data ^ lfsr.
    - out_valid <= 1.
    - lfsr <= lfsr_next.
    - word_count <= word_count+1.
  - No accept and out_ready=1: out_valid <= 0, out_data held.
  - out_valid=1 and out_ready=0: out_data, out_valid and lfsr all held stable. No input is lost.
- Latency: 1 cycle from accept to out_valid.
  - Full throughput, one word per cycle, when out_ready stays high.
  - Simultaneous output drain and input accept in the same cycle is required (no bubble).
- LFSR step (one step per accepted word):
  - lfsr_next = {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? POLY : 0).
  - The keystream for word k is the LFSR state before step k.
  - lfsr never reaches 0: the seed-0 substitution guarantees this, and the property is assertable.
- word_count wraps 16'hFFFF → 16'h0000 with no flag.
- Reset mid-stream: all state clears immediately. The block must be re-seeded before further words are accepted.
- The transmit-side scrambler with the same POLY and seed gives the identity: descramble(scramble(x)) == x for every word sequence.

Test Plan:
- Reset then in_valid=1 without a seed → in_ready=0, out_valid=0, synced=0 for 10 cycles. seed_load → synced=1 next cycle.
- seed=0x00000001, in_data 0x12345678 then 0xFFFFFFFF, out_ready=1:
  - out_data = 0x12345679, then 0xFFFFFFFD (key 0x00000002), back-to-back.
  - word_count=2.
- seed=0x80000000, inputs 0x80000000 then 0x00000000:
  - Outputs 0x00000000 then 0x04C11DB7, exercising the feedback tap.
- seed=0x00000000 (zero substitution), inputs 0x00000000, 0x00000000:
  - Outputs 0xFFFFFFFF then 0xFB3EE249.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1:
  - First word held stable, in_ready=0, lfsr frozen.
  - On release, the sequence continues with no gap or duplicate.
- seed_load while out_valid=1 and out_ready=0 → out_valid drops, word_count=0, and the next word uses the new seed. Also drive a 65537-word run and check word_count wraps to 1.

Source files
------------

// File: rtl/xor_stream_descrambler.sv
// Receive-side additive descrambler: XORs each accepted 32-bit word with a Galois LFSR keystream,
// registering the result behind a single valid/ready output stage.
module xor_stream_descrambler #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] POLY         = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_count,
    output logic             synced
);

    typedef enum logic {
        WAIT_SEED = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      word_count_q, word_count_d;
    logic             accept;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] shifted;
        shifted = {cur[WIDTH-2:0], 1'b0};
        return cur[WIDTH-1] ? (shifted ^ POLY) : shifted;
    endfunction

    // A zero seed would lock the LFSR at zero forever, so it is replaced.
    function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
        return (s == '0) ? SEED_DEFAULT : s;
    endfunction

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        if (seed_load) begin
            state_d      = RUN;
            lfsr_d       = seed_fix(seed);
            out_valid_d  = 1'b0;
            word_count_d = 16'd0;
        end else if (accept) begin
            out_data_d   = in_data ^ lfsr_q;
            out_valid_d  = 1'b1;
            lfsr_d       = lfsr_step(lfsr_q);
            word_count_d = word_count_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_SEED;
            lfsr_q       <= SEED_DEFAULT;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;
    assign synced     = (state_q == RUN);

    lfsr_nonzero_a : assert property (@(posedge clk) disable iff (!reset) lfsr_q != '0);

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler: known-answer vectors, backpressure, re-seed, wrap, reset.
module tb_xor_stream_descrambler;

    logic        clk;
    logic        reset;
    logic        seed_load;
    logic [31:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_count;
    logic        synced;

    int vectors;
    int miscompares;

    xor_stream_descrambler dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed       (seed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .word_count (word_count),
        .synced     (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] key_next(input logic [31:0] k);
        return k[31] ? ({k[30:0], 1'b0} ^ 32'h04C11DB7) : {k[30:0], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_load = 1'b1;
        seed      = s;
        in_valid  = 1'b0;
        #1;
        chk("in_ready_during_seed", {31'd0, in_ready}, 32'd0);
        cyc();
        seed_load = 1'b0;
        chk("synced_after_seed", {31'd0, synced}, 32'd1);
        chk("count_after_seed", {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        logic [31:0] key;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        seed_load   = 1'b0;
        seed        = 32'd0;
        in_valid    = 1'b1;
        in_data     = 32'hDEADBEEF;
        out_ready   = 1'b1;

        // reset values
        cyc();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_synced", {31'd0, synced}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;

        // no seed yet: nothing accepted
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("noseed_in_ready", {31'd0, in_ready}, 32'd0);
            chk("noseed_out_valid", {31'd0, out_valid}, 32'd0);
            chk("noseed_synced", {31'd0, synced}, 32'd0);
        end

        // seed 1: keys 1, 2
        load_seed(32'h00000001);
        chk("seed1_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        #1;
        chk("seed1_in_ready0", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("seed1_w0_valid", {31'd0, out_valid}, 32'd1);
        chk("seed1_w0_data", out_data, 32'h12345679);
        in_data = 32'hFFFFFFFF;
        #1;
        chk("seed1_in_ready1", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("seed1_w1_valid", {31'd0, out_valid}, 32'd1);
        chk("seed1_w1_data", out_data, 32'hFFFFFFFD);
        chk("seed1_count", {16'd0, word_count}, 32'd2);
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_data_held", out_data, 32'hFFFFFFFD);

        // feedback tap
        load_seed(32'h80000000);
        in_valid = 1'b1;
        in_data  = 32'h80000000;
        cyc();
        chk("tap_w0_data", out_data, 32'h00000000);
        in_data = 32'h00000000;
        cyc();
        chk("tap_w1_data", out_data, 32'h04C11DB7);
        in_valid = 1'b0;
        cyc();

        // zero seed substitution
        load_seed(32'h00000000);
        in_valid = 1'b1;
        in_data  = 32'h00000000;
        cyc();
        chk("zseed_w0_data", out_data, 32'hFFFFFFFF);
        cyc();
        chk("zseed_w1_data", out_data, 32'hFB3EE249);
        in_valid = 1'b0;
        cyc();

        // backpressure: keys 1, 2, 4
        load_seed(32'h00000001);
        in_valid = 1'b1;
        in_data  = 32'hA0A0A0A0;
        cyc();
        chk("bp_w0_data", out_data, 32'hA0A0A0A1);
        out_ready = 1'b0;
        in_data   = 32'hA1A1A1A1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            cyc();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", out_data, 32'hA0A0A0A1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("bp_w1_data", out_data, 32'hA1A1A1A3);
        in_data = 32'hA2A2A2A2;
        cyc();
        chk("bp_w2_data", out_data, 32'hA2A2A2A6);
        chk("bp_count", {16'd0, word_count}, 32'd3);
        in_valid = 1'b0;
        cyc();

        // re-seed while stalled
        load_seed(32'h00000001);
        in_valid = 1'b1;
        in_data  = 32'hB0B0B0B0;
        cyc();
        chk("rs_w0_data", out_data, 32'hB0B0B0B1);
        out_ready = 1'b0;
        in_data   = 32'hB1B1B1B1;
        cyc();
        chk("rs_stall_valid", {31'd0, out_valid}, 32'd1);
        seed_load = 1'b1;
        seed      = 32'h80000000;
        cyc();
        seed_load = 1'b0;
        chk("rs_valid_dropped", {31'd0, out_valid}, 32'd0);
        chk("rs_count_zero", {16'd0, word_count}, 32'd0);
        #1;
        chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("rs_new_key_data", out_data, 32'h31B1B1B1);
        chk("rs_new_key_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cyc();

        // 65537-word wrap run
        load_seed(32'h00000001);
        key       = 32'h00000001;
        in_valid  = 1'b1;
        in_data   = 32'h00000000;
        for (int i = 1; i <= 65537; i++) begin
            cyc();
            if (i == 65535) chk("wrap_ffff", {16'd0, word_count}, 32'h0000FFFF);
            if (i == 65536) chk("wrap_zero", {16'd0, word_count}, 32'd0);
            if (i == 65537) chk("wrap_last_key", out_data, key);
            if (i < 65537) key = key_next(key);
        end
        chk("wrap_one", {16'd0, word_count}, 32'd1);

        // asynchronous reset mid-stream
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, word_count}, 32'd0);
        chk("mid_rst_synced", {31'd0, synced}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
